riscv_pipe_core: RTL

//  Single-clock, parametrised 5-stage pipelined core (IF/ID/EX/MEM/WB) replacing the two-phase clk1/clk2 core.

---
 rtl/riscv_pipe_core.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_pipe_core.sv
// rtl/riscv_pipe_core.sv - 5-stage single-clock pipelined core with forwarding, load-use interlock, branch flush
module riscv_pipe_core #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int FORWARDING = 1,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [XLEN-1:0] load_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            halted,
  output logic [AW-1:0]   pc,
  output logic [31:0]     retire_cnt
);

  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02, OP_OR = 6'h03;
  localparam logic [5:0] OP_SLT = 6'h04, OP_MUL = 6'h05, OP_LW = 6'h08, OP_SW = 6'h09;
  localparam logic [5:0] OP_ADDI = 6'h0A, OP_SUBI = 6'h0B, OP_SLTI = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D, OP_BEQZ = 6'h0E, OP_HLT = 6'h3F;
  // One bit per architectural register index that actually exists
  localparam logic [31:0] REG_OK = (NREG >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NREG) - 32'd1);

  logic [XLEN-1:0] r_mem  [MEM_DEPTH];
  logic [XLEN-1:0] r_regs [32];
  logic [AW-1:0]   r_pc;
  logic            r_halted;
  logic [31:0]     r_retire;

  logic            r_ifid_v;
  logic [31:0]     r_ifid_ir;
  logic [AW-1:0]   r_ifid_pc;
  logic            r_idex_v, r_idex_we;
  logic [5:0]      r_idex_op;
  logic [4:0]      r_idex_rs, r_idex_rt, r_idex_dst;
  logic [XLEN-1:0] r_idex_a, r_idex_b, r_idex_imm;
  logic [AW-1:0]   r_idex_pc;
  logic            r_exmem_v, r_exmem_we;
  logic [5:0]      r_exmem_op;
  logic [4:0]      r_exmem_dst;
  logic [XLEN-1:0] r_exmem_res, r_exmem_b;
  logic            r_memwb_v, r_memwb_we;
  logic [5:0]      r_memwb_op;
  logic [4:0]      r_memwb_dst;
  logic [XLEN-1:0] r_memwb_res;

  logic [5:0]      w_id_op;
  logic [4:0]      w_id_rs, w_id_rt, w_id_dst;
  logic [XLEN-1:0] w_id_imm, w_id_a, w_id_b;
  logic            w_id_rtype, w_id_itype, w_id_we, w_halt_pend;
  logic            w_hit_ex, w_hit_mem, w_stall;
  logic [XLEN-1:0] w_ex_a, w_ex_b, w_ex_bsrc, w_ex_res;
  logic            w_ex_taken;
  logic [AW-1:0]   w_ex_target, w_mem_addr;
  logic [XLEN-1:0] w_mem_res;
  logic [31:0]     w_fetch;

  assign w_id_op    = r_ifid_ir[31:26];
  assign w_id_rs    = r_ifid_ir[25:21];
  assign w_id_rt    = r_ifid_ir[20:16];
  assign w_id_imm   = {{(XLEN-16){r_ifid_ir[15]}}, r_ifid_ir[15:0]};
  assign w_id_rtype = (w_id_op <= OP_MUL);
  assign w_id_itype = (w_id_op == OP_LW) || (w_id_op == OP_ADDI) || (w_id_op == OP_SUBI) || (w_id_op == OP_SLTI);
  assign w_id_dst   = w_id_rtype ? r_ifid_ir[15:11] : w_id_rt;
  assign w_id_we    = r_ifid_v && (w_id_rtype || w_id_itype) && (w_id_dst != 5'd0) && REG_OK[w_id_dst];

  // Register file read is write-first against the instruction retiring this cycle
  always_comb begin
    w_id_a = r_regs[w_id_rs];
    w_id_b = r_regs[w_id_rt];
    if (r_memwb_v && r_memwb_we && r_memwb_dst == w_id_rs) w_id_a = r_memwb_res;
    if (r_memwb_v && r_memwb_we && r_memwb_dst == w_id_rt) w_id_b = r_memwb_res;
    if (w_id_rs == 5'd0 || !REG_OK[w_id_rs]) w_id_a = '0;
    if (w_id_rt == 5'd0 || !REG_OK[w_id_rt]) w_id_b = '0;
  end

  assign dbg_data = (dbg_addr == 5'd0 || !REG_OK[dbg_addr]) ? '0 : r_regs[dbg_addr];

  assign w_halt_pend = (r_ifid_v && w_id_op == OP_HLT) || (r_idex_v && r_idex_op == OP_HLT) ||
                       (r_exmem_v && r_exmem_op == OP_HLT) || (r_memwb_v && r_memwb_op == OP_HLT);
  assign w_hit_ex  = r_idex_v && r_idex_we && (r_idex_dst == w_id_rs || r_idex_dst == w_id_rt);
  assign w_hit_mem = r_exmem_v && r_exmem_we && (r_exmem_dst == w_id_rs || r_exmem_dst == w_id_rt);
  assign w_stall   = r_ifid_v && ((FORWARDING != 0) ? (w_hit_ex && r_idex_op == OP_LW) : (w_hit_ex || w_hit_mem));

  // A load sitting in EX/MEM is never forwarded: the interlock keeps its consumer out of EX
  always_comb begin
    w_ex_a = r_idex_a;
    w_ex_b = r_idex_b;
    if (FORWARDING != 0) begin
      if (r_exmem_v && r_exmem_we && r_exmem_op != OP_LW && r_exmem_dst == r_idex_rs) w_ex_a = r_exmem_res;
      else if (r_memwb_v && r_memwb_we && r_memwb_dst == r_idex_rs) w_ex_a = r_memwb_res;
      if (r_exmem_v && r_exmem_we && r_exmem_op != OP_LW && r_exmem_dst == r_idex_rt) w_ex_b = r_exmem_res;
      else if (r_memwb_v && r_memwb_we && r_memwb_dst == r_idex_rt) w_ex_b = r_memwb_res;
    end
  end

  assign w_ex_bsrc = (r_idex_op >= OP_LW && r_idex_op <= OP_SLTI) ? r_idex_imm : w_ex_b;

  always_comb begin
    w_ex_res = '0;
    case (r_idex_op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: w_ex_res = w_ex_a + w_ex_bsrc;
      OP_SUB, OP_SUBI:               w_ex_res = w_ex_a - w_ex_bsrc;
      OP_AND:                        w_ex_res = w_ex_a & w_ex_b;
      OP_OR:                         w_ex_res = w_ex_a | w_ex_b;
      OP_SLT, OP_SLTI:               w_ex_res = {{(XLEN-1){1'b0}}, ($signed(w_ex_a) < $signed(w_ex_bsrc))};
      OP_MUL:                        w_ex_res = w_ex_a * w_ex_b;
      default:                       w_ex_res = '0;
    endcase
  end

  assign w_ex_taken  = r_idex_v && ((r_idex_op == OP_BNEQZ && w_ex_a != '0) || (r_idex_op == OP_BEQZ && w_ex_a == '0));
  assign w_ex_target = r_idex_pc + AW'(1) + r_idex_imm[AW-1:0];
  assign w_mem_addr  = r_exmem_res[AW-1:0];
  assign w_mem_res   = (r_exmem_op == OP_LW) ? r_mem[w_mem_addr] : r_exmem_res;
  assign w_fetch     = r_mem[r_pc][31:0];

  always_ff @(posedge clk) begin
    if (load_en && (rst || r_halted)) r_mem[load_addr] <= load_data;
    else if (!rst && !r_halted && r_exmem_v && r_exmem_op == OP_SW) r_mem[w_mem_addr] <= r_exmem_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= '0;
      r_halted   <= 1'b0;
      r_retire   <= '0;
      r_ifid_v   <= 1'b0;
      r_idex_v   <= 1'b0;
      r_idex_we  <= 1'b0;
      r_exmem_v  <= 1'b0;
      r_exmem_we <= 1'b0;
      r_memwb_v  <= 1'b0;
      r_memwb_we <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (!r_halted) begin
      if (r_memwb_v) begin
        r_retire <= r_retire + 32'd1;
        if (r_memwb_we) r_regs[r_memwb_dst] <= r_memwb_res;
        if (r_memwb_op == OP_HLT) r_halted <= 1'b1;
      end
      r_memwb_v   <= r_exmem_v;
      r_memwb_op  <= r_exmem_op;
      r_memwb_res <= w_mem_res;
      r_memwb_dst <= r_exmem_dst;
      r_memwb_we  <= r_exmem_v && r_exmem_we;
      r_exmem_v   <= r_idex_v;
      r_exmem_op  <= r_idex_op;
      r_exmem_res <= w_ex_res;
      r_exmem_b   <= w_ex_b;
      r_exmem_dst <= r_idex_dst;
      r_exmem_we  <= r_idex_v && r_idex_we;
      if (w_ex_taken) begin
        r_pc      <= w_ex_target;
        r_ifid_v  <= 1'b0;
        r_idex_v  <= 1'b0;
        r_idex_we <= 1'b0;
      end else if (w_stall) begin
        r_idex_v  <= 1'b0;
        r_idex_we <= 1'b0;
      end else begin
        r_idex_v   <= r_ifid_v;
        r_idex_we  <= w_id_we;
        r_idex_op  <= w_id_op;
        r_idex_rs  <= w_id_rs;
        r_idex_rt  <= w_id_rt;
        r_idex_dst <= w_id_dst;
        r_idex_a   <= w_id_a;
        r_idex_b   <= w_id_b;
        r_idex_imm <= w_id_imm;
        r_idex_pc  <= r_ifid_pc;
        // HLT anywhere in flight freezes fetch; only an older taken branch can undo it
        if (w_halt_pend) begin
          r_ifid_v <= 1'b0;
        end else begin
          r_ifid_v  <= 1'b1;
          r_ifid_ir <= w_fetch;
          r_ifid_pc <= r_pc;
          r_pc      <= r_pc + AW'(1);
        end
      end
    end
  end

  assign halted     = r_halted;
  assign pc         = r_pc;
  assign retire_cnt = r_retire;

endmodule
